// File: rtl/envelope_sequencer_pkg.sv
// Shared types and constants for the envelope sequencer: voice configuration,
// per-voice envelope state and the saturating gain update.
package envelope_sequencer_pkg;

  localparam int N_OSC   = 4;
  localparam int ENV_LEN = 4;
  localparam int GAIN_W  = 32;
  localparam int TIME_W  = 16;
  localparam int STAGE_W = (ENV_LEN > 1) ? $clog2(ENV_LEN) : 1;
  localparam int VIDX_W  = (N_OSC > 1) ? $clog2(N_OSC) : 1;

  // rate is a signed two's-complement step; time_val counts samples
  typedef struct packed {
    logic [GAIN_W-1:0] rate;
    logic [TIME_W-1:0] time_val;
  } envelope_t;

  typedef struct packed {
    envelope_t [N_OSC-1:0][ENV_LEN-1:0] envelopes;
  } synth_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SUSTAIN = 2'd2
  } env_phase_t;

  typedef struct packed {
    env_phase_t         phase;
    logic [STAGE_W-1:0] stage;
    logic [TIME_W-1:0]  remaining;
    logic [GAIN_W-1:0]  gain;
    logic               gate_q;
  } env_voice_t;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  // A carry out of the one-bit-wider sum means overflow for a positive rate
  // and underflow for a negative one.
  function automatic logic [GAIN_W-1:0] sat_add(input logic [GAIN_W-1:0] g_in,
                                                input logic [GAIN_W-1:0] r_in);
    logic [GAIN_W:0] sum;
    sum = {1'b0, g_in} + {r_in[GAIN_W-1], r_in};
    if (sum[GAIN_W]) begin
      return r_in[GAIN_W-1] ? '0 : '1;
    end
    return sum[GAIN_W-1:0];
  endfunction

endpackage

// File: rtl/envelope_sequencer_step.sv
// Combinational single-voice envelope update, shared by all voices through the
// scan index of the sequencer.
module envelope_sequencer_step
  import envelope_sequencer_pkg::*;
(
  input  env_voice_t               cur,
  input  logic                     g,
  input  envelope_t [ENV_LEN-1:0]  env,
  output env_voice_t               nxt
);

  logic [TIME_W-1:0] rem;

  always_comb begin
    nxt        = cur;
    nxt.gate_q = g;
    rem        = cur.remaining;
    if (g && !cur.gate_q) begin
      nxt.phase     = RUN;
      nxt.stage     = '0;
      nxt.remaining = env[0].time_val;
      nxt.gain      = '0;
    end else if (!g && cur.gate_q && (cur.phase != IDLE)) begin
      nxt.phase     = RUN;
      nxt.stage     = STAGE_W'(ENV_LEN-1);
      nxt.remaining = env[ENV_LEN-1].time_val;
    end else if (cur.phase == RUN) begin
      // a zero-length stage falls straight through to the advance below
      if (rem != '0) begin
        nxt.gain = sat_add(cur.gain, env[cur.stage].rate);
        rem      = rem - TIME_W'(1);
      end
      nxt.remaining = rem;
      if (rem == '0) begin
        if (cur.stage == STAGE_W'(ENV_LEN-1)) begin
          nxt.phase = IDLE;
          nxt.gain  = '0;
          nxt.stage = '0;
        end else if (cur.stage == STAGE_W'(ENV_LEN-2)) begin
          nxt.phase = SUSTAIN;
        end else begin
          nxt.stage     = cur.stage + STAGE_W'(1);
          nxt.remaining = env[cur.stage + STAGE_W'(1)].time_val;
        end
      end
    end
  end

endmodule

// File: rtl/envelope_sequencer.sv
// Time-multiplexed envelope sequencer: on each sample tick, walks every voice
// once through the shared step datapath and flags completion with gain_valid.
//
// state | meaning
// WAIT  | idle, waiting for sample_tick
// SCAN  | updating voice v_q this cycle
// FIN   | all voices done; gain_valid asserted on exit
module envelope_sequencer
  import envelope_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sample_tick,
  input  synth_t                   synth_cfg,
  input  logic [N_OSC-1:0]         gate,
  output logic [N_OSC*GAIN_W-1:0]  gain,
  output logic                     gain_valid,
  output logic [N_OSC-1:0]         active,
  output logic                     overrun
);

  seq_state_t              state_q, state_d;
  logic [VIDX_W-1:0]       v_q, v_d;
  env_voice_t [N_OSC-1:0]  voice_q, voice_d;
  logic                    gain_valid_q, gain_valid_d;
  logic                    overrun_q, overrun_d;
  env_voice_t              step_nxt;

  envelope_sequencer_step u_step (
    .cur (voice_q[v_q]),
    .g   (gate[v_q]),
    .env (synth_cfg.envelopes[v_q]),
    .nxt (step_nxt)
  );

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    voice_d      = voice_q;
    gain_valid_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      WAIT: begin
        if (sample_tick) begin
          state_d = SCAN;
          v_d     = '0;
        end
      end
      SCAN: begin
        voice_d[v_q] = step_nxt;
        if (sample_tick) overrun_d = 1'b1;
        if (v_q == VIDX_W'(N_OSC-1)) state_d = FIN;
        else                         v_d     = v_q + VIDX_W'(1);
      end
      FIN: begin
        gain_valid_d = 1'b1;
        state_d      = WAIT;
        if (sample_tick) overrun_d = 1'b1;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= WAIT;
      v_q          <= '0;
      voice_q      <= '0;
      gain_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      voice_q      <= voice_d;
      gain_valid_q <= gain_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  for (genvar i = 0; i < N_OSC; i++) begin : g_out
    assign gain[i*GAIN_W +: GAIN_W] = voice_q[i].gain;
    assign active[i]                = (voice_q[i].phase != IDLE);
  end

  assign gain_valid = gain_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Self-checking bench for envelope_sequencer: table-driven ticks with a
// scoreboard of expected gains popped on gain_valid, plus slot/overrun/reset sequences.
`timescale 1ns/1ps
module tb_envelope_sequencer;
  import envelope_sequencer_pkg::*;

  localparam int GW = N_OSC*GAIN_W;

  typedef struct {
    int               id;
    logic [N_OSC-1:0] gate;
    logic [GW-1:0]    gain;
    logic [N_OSC-1:0] active;
  } vec_t;

  logic             clk;
  logic             rstn;
  logic             sample_tick;
  synth_t           cfg;
  logic [N_OSC-1:0] gate;
  logic [GW-1:0]    gain;
  logic             gain_valid;
  logic [N_OSC-1:0] active;
  logic             overrun;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   row_id  = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  envelope_sequencer dut (
    .clk         (clk),
    .rstn        (rstn),
    .sample_tick (sample_tick),
    .synth_cfg   (cfg),
    .gate        (gate),
    .gain        (gain),
    .gain_valid  (gain_valid),
    .active      (active),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] g, input logic [31:0] g0, input logic [31:0] g1,
                              input logic [31:0] g2, input logic [31:0] g3, input logic [3:0] act);
    vec_t v;
    v.id     = 0;
    v.gate   = g;
    v.gain   = {g3, g2, g1, g0};
    v.active = act;
    return v;
  endfunction

  task automatic set_env(input int v, input int s, input logic [31:0] rate, input logic [15:0] t);
    cfg.envelopes[v][s].rate     = rate;
    cfg.envelopes[v][s].time_val = t;
  endtask

  // Scoreboard consumer: every gain_valid must match the oldest expected row.
  always @(posedge clk) begin
    vec_t e;
    #1;
    if (gain_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gain_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("gain_row%0d", e.id), gain, e.gain);
        check($sformatf("active_row%0d", e.id), active, e.active);
      end
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (gain_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_tick(input vec_t v);
    int n;
    v.id = row_id++;
    exp_q.push_back(v);
    gate        = v.gate;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    wait_valid(n);
    check($sformatf("valid_latency_row%0d", v.id), n, N_OSC+1);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) do_tick(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   n;
    rstn = 1'b0; sample_tick = 1'b0; gate = '0; cfg = '0;

    // Reset held with ticks applied
    for (int k = 0; k < 3; k++) begin
      sample_tick = 1'b1;
      @(posedge clk); #1;
      check("rst_gain_valid", gain_valid, 0);
    end
    sample_tick = 1'b0;
    check("rst_gain", gain, 0);
    check("rst_active", active, 0);
    check("rst_overrun", overrun, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Attack / decay / sustain-entry / release on voice 0
    set_env(0, 0, 100, 4);
    set_env(0, 1, -32'sd10, 2);
    set_env(0, 2, 0, 1);
    set_env(0, 3, -32'sd50, 3);
    tbl.push_back(mk(4'b0001, 0,   0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 100, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 200, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 300, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 400, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 390, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 380, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 380, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 380, 0, 0, 0, 4'b0001));
    run_tbl();
    for (int k = 0; k < 50; k++) do_tick(mk(4'b0001, 380, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0000, 380, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0000, 330, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0000, 280, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(4'b0000, 0,   0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 0,   0, 0, 0, 4'b0000));
    run_tbl();

    // Saturation both ways on voice 1
    set_env(1, 0, 32'h7FFF_FFFF, 3);
    set_env(1, 1, 0, 1);
    set_env(1, 2, 0, 1);
    set_env(1, 3, 32'h8000_0000, 3);
    tbl.push_back(mk(4'b0010, 0, 0,            0, 0, 4'b0010));
    tbl.push_back(mk(4'b0010, 0, 32'h7FFFFFFF, 0, 0, 4'b0010));
    tbl.push_back(mk(4'b0010, 0, 32'hFFFFFFFE, 0, 0, 4'b0010));
    tbl.push_back(mk(4'b0010, 0, 32'hFFFFFFFF, 0, 0, 4'b0010));
    tbl.push_back(mk(4'b0010, 0, 32'hFFFFFFFF, 0, 0, 4'b0010));
    tbl.push_back(mk(4'b0010, 0, 32'hFFFFFFFF, 0, 0, 4'b0010));
    tbl.push_back(mk(4'b0000, 0, 32'hFFFFFFFF, 0, 0, 4'b0010));
    tbl.push_back(mk(4'b0000, 0, 32'h7FFFFFFF, 0, 0, 4'b0010));
    tbl.push_back(mk(4'b0000, 0, 0,            0, 0, 4'b0010));
    tbl.push_back(mk(4'b0000, 0, 0,            0, 0, 4'b0000));
    run_tbl();

    // Zero-length stage and retrigger during release on voice 2
    set_env(2, 0, 10, 2);
    set_env(2, 1, 999, 0);
    set_env(2, 2, 5, 2);
    set_env(2, 3, -32'sd1, 4);
    tbl.push_back(mk(4'b0100, 0, 0, 0,  0, 4'b0100));
    tbl.push_back(mk(4'b0100, 0, 0, 10, 0, 4'b0100));
    tbl.push_back(mk(4'b0100, 0, 0, 20, 0, 4'b0100));
    tbl.push_back(mk(4'b0100, 0, 0, 20, 0, 4'b0100));
    tbl.push_back(mk(4'b0100, 0, 0, 25, 0, 4'b0100));
    tbl.push_back(mk(4'b0100, 0, 0, 30, 0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 0, 30, 0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 0, 29, 0, 4'b0100));
    tbl.push_back(mk(4'b0100, 0, 0, 0,  0, 4'b0100));
    tbl.push_back(mk(4'b0100, 0, 0, 10, 0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 0, 10, 0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 0, 9,  0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 0, 8,  0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 0, 7,  0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 0, 0,  0, 4'b0000));
    run_tbl();
    check("overrun_before_concurrency", overrun, 0);

    // All voices together, distinct rates
    cfg = '0;
    for (int i = 0; i < N_OSC; i++) begin
      set_env(i, 0, 32'((i+1)*1000), 2);
      set_env(i, 1, 0, 1);
      set_env(i, 2, 0, 1);
      set_env(i, 3, 0, 1);
    end
    do_tick(mk(4'b1111, 0, 0, 0, 0, 4'b1111));

    // Each voice changes exactly in its own slot
    e = mk(4'b1111, 1000, 2000, 3000, 4000, 4'b1111);
    e.id = row_id++;
    exp_q.push_back(e);
    gate = 4'b1111; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int i = 0; i < N_OSC; i++) begin
      @(posedge clk); #1;
      check($sformatf("slot%0d_updated", i), gain[i*GAIN_W +: GAIN_W], e.gain[i*GAIN_W +: GAIN_W]);
      if (i < N_OSC-1)
        check($sformatf("slot%0d_next_unchanged", i), gain[(i+1)*GAIN_W +: GAIN_W], 0);
    end
    wait_valid(n);
    check("slot_valid_latency", n, 1);

    // Tick arriving mid-scan is dropped and flagged
    e = mk(4'b1111, 2000, 4000, 6000, 8000, 4'b1111);
    e.id = row_id++;
    exp_q.push_back(e);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    wait_valid(n);
    check("overrun_valid_latency", n, N_OSC-1);
    check("overrun_set", overrun, 1);
    repeat (N_OSC+3) begin @(posedge clk); #1; end
    check("overrun_gain_unaffected", gain, e.gain);
    check("overrun_sticky", overrun, 1);

    // Reset in the middle of a scan
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midscan_rst_gain", gain, 0);
    check("midscan_rst_active", active, 0);
    check("midscan_rst_valid", gain_valid, 0);
    check("midscan_rst_overrun", overrun, 0);
    rstn = 1'b1;
    repeat (N_OSC+4) begin @(posedge clk); #1; end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
